// File: rtl/int_div_unit_pkg.sv
// Shared operation types for the integer divider: command encoding and decode helpers.
package OpTypes;

    typedef enum logic [1:0] {
        Div  = 2'd0,
        Divu = 2'd1,
        Rem  = 2'd2,
        Remu = 2'd3
    } DivCommand;

    function automatic logic isSigned(DivCommand c);
        return (c == Div) || (c == Rem);
    endfunction

    function automatic logic isRem(DivCommand c);
        return (c == Rem) || (c == Remu);
    endfunction

endpackage

// File: rtl/int_div_step.sv
// One combinational restoring-division step: shift one dividend bit into the partial
// remainder and subtract the divisor when it fits.
module int_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_nxt,
    output logic [WIDTH-1:0] q_nxt
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] dvsr_ext;
    logic           ge;

    // The shifted remainder can reach WIDTH+1 bits when the divisor has its MSB set.
    assign shifted  = {rem, q[WIDTH-1]};
    assign dvsr_ext = {1'b0, divisor};
    assign ge       = (shifted >= dvsr_ext);
    assign rem_nxt  = WIDTH'(ge ? (shifted - dvsr_ext) : shifted);
    assign q_nxt    = {q[WIDTH-2:0], ge};

endmodule

// File: rtl/int_div_unit.sv
// Iterative RV32M divider (DIV/DIVU/REM/REMU) answering the execute stage's multi-cycle handshake.
// States: IDLE waits for enable | RUN iterates restoring steps | DONE presents result for one cycle.
module int_div_unit
    import OpTypes::*;
#(
    parameter int WIDTH           = 32,
    parameter int STEPS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  DivCommand        command,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    input  logic             stall,
    input  logic             flush,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    typedef logic [1:0] DivState;
    localparam DivState IDLE = 2'd0;
    localparam DivState RUN  = 2'd1;
    localparam DivState DONE = 2'd2;

    localparam int ITER  = WIDTH / STEPS_PER_CYCLE;
    localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ITER - 1);
    localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

    DivState          state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvsr_q, dvsr_d;
    DivCommand        cmd_q, cmd_d;
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] result_q, result_d;

    logic             sgn_op, s1, s2, ovf;
    logic [WIDTH-1:0] abs1, abs2;
    logic [WIDTH-1:0] rem_fin, quo_fin, run_result;

    logic [WIDTH-1:0] rem_chain [STEPS_PER_CYCLE+1];
    logic [WIDTH-1:0] q_chain   [STEPS_PER_CYCLE+1];

    assign rem_chain[0] = rem_q;
    assign q_chain[0]   = quo_q;

    for (genvar i = 0; i < STEPS_PER_CYCLE; i++) begin : g_step
        int_div_step #(.WIDTH(WIDTH)) u_step (
            .rem     (rem_chain[i]),
            .q       (q_chain[i]),
            .divisor (dvsr_q),
            .rem_nxt (rem_chain[i+1]),
            .q_nxt   (q_chain[i+1])
        );
    end

    assign sgn_op = isSigned(command);
    assign s1     = sgn_op & src1[WIDTH-1];
    assign s2     = sgn_op & src2[WIDTH-1];
    // Negating MIN_NEG yields itself, which is the correct unsigned magnitude.
    assign abs1   = s1 ? -src1 : src1;
    assign abs2   = s2 ? -src2 : src2;
    assign ovf    = sgn_op && (src1 == MIN_NEG) && (src2 == '1);

    assign rem_fin    = rem_chain[STEPS_PER_CYCLE];
    assign quo_fin    = q_chain[STEPS_PER_CYCLE];
    assign run_result = isRem(cmd_q) ? (r_neg_q ? -rem_fin : rem_fin)
                                     : (q_neg_q ? -quo_fin : quo_fin);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvsr_d   = dvsr_q;
        cmd_d    = cmd_q;
        q_neg_d  = q_neg_q;
        r_neg_d  = r_neg_q;
        done_d   = done_q;
        result_d = result_q;

        if (flush) begin
            state_d  = IDLE;
            done_d   = 1'b0;
            result_d = '0;
        end else if (!stall) begin
            case (state_q)
                IDLE: begin
                    done_d   = 1'b0;
                    result_d = '0;
                    if (enable) begin
                        cmd_d   = command;
                        q_neg_d = s1 ^ s2;
                        r_neg_d = s1;
                        if (src2 == '0) begin
                            state_d  = DONE;
                            done_d   = 1'b1;
                            result_d = isRem(command) ? src1 : '1;
                        end else if (ovf) begin
                            state_d  = DONE;
                            done_d   = 1'b1;
                            result_d = isRem(command) ? '0 : src1;
                        end else begin
                            rem_d   = '0;
                            quo_d   = abs1;
                            dvsr_d  = abs2;
                            cnt_d   = CNT_LOAD;
                            state_d = RUN;
                        end
                    end
                end
                RUN: begin
                    rem_d = rem_fin;
                    quo_d = quo_fin;
                    if (cnt_q == '0) begin
                        state_d  = DONE;
                        done_d   = 1'b1;
                        result_d = run_result;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                DONE: begin
                    state_d  = IDLE;
                    done_d   = 1'b0;
                    result_d = '0;
                end
                default: begin
                    state_d  = IDLE;
                    done_d   = 1'b0;
                    result_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvsr_q   <= '0;
            cmd_q    <= Div;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvsr_q   <= dvsr_d;
            cmd_q    <= cmd_d;
            q_neg_q  <= q_neg_d;
            r_neg_q  <= r_neg_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_int_div_unit.sv
// Self-checking bench for int_div_unit: directed vector table, random ops against an
// arithmetic reference, and hand-written flush / stall / reset sequences.
module tb_int_div_unit;
    import OpTypes::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    DivCommand   command;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        stall;
    logic        flush;
    logic        done;
    logic [31:0] result;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    int_div_unit #(.WIDTH(32), .STEPS_PER_CYCLE(1)) dut (
        .clk     (clk),
        .rst     (rst),
        .enable  (enable),
        .command (command),
        .src1    (src1),
        .src2    (src2),
        .stall   (stall),
        .flush   (flush),
        .done    (done),
        .result  (result)
    );

    typedef struct {
        DivCommand   cmd;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // Reference: plain 64-bit signed/unsigned arithmetic plus the RISC-V divide-by-zero rule.
    function automatic logic [31:0] model(DivCommand c, logic [31:0] a, logic [31:0] b);
        bit     sgn = (c == Div) || (c == Rem);
        bit     rm  = (c == Rem) || (c == Remu);
        longint sa, sb, q, r;
        if (b == 32'd0) return rm ? a : 32'hFFFF_FFFF;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return rm ? r[31:0] : q[31:0];
    endfunction

    function automatic int model_lat(DivCommand c, logic [31:0] a, logic [31:0] b);
        bit sgn = (c == Div) || (c == Rem);
        if (b == 32'd0) return 1;
        if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // Starts at #1 after an edge with the DUT idle; returns #1 after the edge following done.
    task automatic run_op(input string name, input DivCommand c, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                          input int stall_at, input int stall_len, input int hold_done);
        int cycles = 0;
        bit got    = 0;
        command = c;
        src1    = a;
        src2    = b;
        enable  = 1'b1;
        while (!got && cycles < 200) begin
            @(posedge clk);
            #1;
            cycles++;
            if (done === 1'b1) got = 1;
            else if (stall_at > 0 && cycles == stall_at) stall = 1'b1;
            else if (stall_at > 0 && cycles == stall_at + stall_len) stall = 1'b0;
        end
        enable = 1'b0;
        stall  = 1'b0;
        check({name, "_latency"}, cycles, exp_lat);
        check({name, "_result"}, result, exp);
        if (hold_done > 0) begin
            stall = 1'b1;
            for (int i = 0; i < hold_done; i++) begin
                @(posedge clk);
                #1;
                check({name, "_held_done"}, {31'd0, done}, 32'd1);
                check({name, "_held_result"}, result, exp);
            end
            stall = 1'b0;
        end
        @(posedge clk);
        #1;
        check({name, "_done_drops"}, {31'd0, done}, 32'd0);
        check({name, "_result_zero"}, result, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int done_seen;
        DivCommand   rc;
        logic [31:0] ra, rb;

        vecs.push_back('{Divu, 32'd100,        32'd7,          32'd14,         33});
        vecs.push_back('{Remu, 32'd100,        32'd7,          32'd2,          33});
        vecs.push_back('{Div,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  33});
        vecs.push_back('{Rem,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  33});
        vecs.push_back('{Div,  32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  33});
        vecs.push_back('{Divu, 32'd5,          32'd0,          32'hFFFF_FFFF,  1});
        vecs.push_back('{Rem,  32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB,  1});
        vecs.push_back('{Div,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1});
        vecs.push_back('{Rem,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1});
        vecs.push_back('{Divu, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          33});
        vecs.push_back('{Remu, 32'hFFFF_FFFF,  32'hFFFF_FFFE,  32'd1,          33});
        vecs.push_back('{Divu, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  33});

        rst = 1'b0; enable = 1'b0; stall = 1'b0; flush = 1'b0;
        command = Divu; src1 = '0; src2 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_result", result, 32'd0);
        rst = 1'b1;

        foreach (vecs[i])
            run_op($sformatf("vec%0d", i), vecs[i].cmd, vecs[i].a, vecs[i].b,
                   vecs[i].exp, vecs[i].lat, 0, 0, 0);

        // Flush at cycle 10 of Divu 1000/3: done must never appear.
        command = Divu; src1 = 32'd1000; src2 = 32'd3; enable = 1'b1;
        done_seen = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) done_seen++;
        end
        flush = 1'b1; enable = 1'b0;
        @(posedge clk);
        #1;
        flush = 1'b0;
        repeat (40) begin
            if (done === 1'b1) done_seen++;
            @(posedge clk);
            #1;
        end
        check("flush_no_done", done_seen, 0);
        run_op("after_flush", Divu, 32'd9, 32'd3, 32'd3, 33, 0, 0, 0);
        run_op("back_to_back", Div, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 33, 0, 0, 0);

        // Three stalled edges mid-RUN push done out by three cycles.
        run_op("stall_run", Divu, 32'd1000, 32'd7, 32'd142, 36, 5, 3, 0);
        // Stall while in DONE holds done and result.
        run_op("stall_done", Remu, 32'd1000, 32'd7, 32'd6, 33, 0, 0, 2);

        // Reset mid-RUN, with stall raised to confirm reset wins.
        command = Divu; src1 = 32'd50; src2 = 32'd5; enable = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b0; stall = 1'b1;
        @(posedge clk);
        #1;
        check("rst_mid_run_done", {31'd0, done}, 32'd0);
        check("rst_mid_run_result", result, 32'd0);
        rst = 1'b1; stall = 1'b0; enable = 1'b0;
        done_seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) done_seen++;
        end
        check("rst_no_done", done_seen, 0);
        run_op("after_reset", Divu, 32'd50, 32'd5, 32'd10, 33, 0, 0, 0);

        for (int i = 0; i < 40; i++) begin
            rc = DivCommand'($urandom_range(0, 3));
            ra = $urandom;
            case ($urandom_range(0, 5))
                0: rb = $urandom;
                1: rb = $urandom_range(1, 20);
                2: rb = 32'hFFFF_FF00 | $urandom_range(0, 255);
                3: rb = 32'd0;
                4: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                default: rb = $urandom >> $urandom_range(0, 31);
            endcase
            run_op($sformatf("rand%0d", i), rc, ra, rb, model(rc, ra, rb),
                   model_lat(rc, ra, rb), 0, 0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
